// File: rtl/avalon_burst_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst master between NUM_REQ requesters.
// Holds the grant for a whole read or write burst and routes beats back to the owner.
module avalon_burst_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 1024,
    parameter int BEW     = DW/8,
    parameter int BCW     = 11
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [NUM_REQ-1:0]     rq_valid,
    input  logic [NUM_REQ-1:0]     rq_write,
    input  logic [NUM_REQ*AW-1:0]  rq_addr,
    input  logic [NUM_REQ*BCW-1:0] rq_burstcount,
    input  logic [NUM_REQ*BEW-1:0] rq_byteenable,
    input  logic [NUM_REQ*DW-1:0]  rq_wdata,
    output logic [NUM_REQ-1:0]     rq_ready,
    output logic [NUM_REQ-1:0]     rq_wready,
    output logic [NUM_REQ-1:0]     rq_rvalid,
    output logic [DW-1:0]          rq_rdata,
    output logic [NUM_REQ-1:0]     rq_done,
    output logic [AW-1:0]          avm_address,
    output logic [BCW-1:0]         avm_burstcount,
    output logic                   avm_beginbursttransfer,
    output logic                   avm_chipselect,
    output logic                   avm_read,
    output logic                   avm_write,
    output logic [BEW-1:0]         avm_byteenable,
    output logic [DW-1:0]          avm_writedata,
    input  logic [DW-1:0]          avm_readdata,
    input  logic                   avm_waitrequest,
    input  logic                   avm_readdatavalid
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ZLEN, WR, RD_CMD, RD_DATA} state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        grant, last_grant, winner, cand;
    logic                 found;
    int                   tmp;
    logic [AW-1:0]        addr_r;
    logic [BCW-1:0]       bc_r, cnt;
    logic                 first;
    logic                 ack, wbeat, rbeat, done;
    logic [NUM_REQ-1:0]   gsel;

    logic [AW-1:0]  addr_a [NUM_REQ];
    logic [BCW-1:0] bc_a   [NUM_REQ];
    logic [BEW-1:0] be_a   [NUM_REQ];
    logic [DW-1:0]  wd_a   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g] = rq_addr[g*AW +: AW];
        assign bc_a[g]   = rq_burstcount[g*BCW +: BCW];
        assign be_a[g]   = rq_byteenable[g*BEW +: BEW];
        assign wd_a[g]   = rq_wdata[g*DW +: DW];
    end

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        cand   = '0;
        tmp    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tmp  = (int'(last_grant) + 1 + i) % NUM_REQ;
            cand = GW'(tmp);
            if (!found && rq_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt              = state;
        avm_chipselect         = 1'b0;
        avm_read               = 1'b0;
        avm_write              = 1'b0;
        avm_beginbursttransfer = 1'b0;
        ack                    = 1'b0;
        wbeat                  = 1'b0;
        rbeat                  = 1'b0;
        done                   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    if (bc_a[winner] == '0)
                        state_nxt = ZLEN;
                    else if (rq_write[winner])
                        state_nxt = WR;
                    else
                        state_nxt = RD_CMD;
                end
            end
            ZLEN: begin
                ack       = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            WR: begin
                avm_write              = 1'b1;
                avm_chipselect         = 1'b1;
                avm_beginbursttransfer = first;
                ack                    = first;
                wbeat                  = !avm_waitrequest;
                if (wbeat && cnt == bc_r - BCW'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_CMD: begin
                avm_read               = 1'b1;
                avm_chipselect         = 1'b1;
                avm_beginbursttransfer = first;
                ack                    = first;
                rbeat                  = avm_readdatavalid;
                if (rbeat && cnt == bc_r - BCW'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (!avm_waitrequest) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                rbeat = avm_readdatavalid;
                if (rbeat && cnt == bc_r - BCW'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant      <= '0;
            first      <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cnt   <= '0;
                first <= found;
                if (found) begin
                    grant      <= winner;
                    last_grant <= winner;
                end
            end else begin
                first <= 1'b0;
                if (wbeat || rbeat)
                    cnt <= cnt + BCW'(1);
            end
        end
    end

    // Command fields are captured at grant time; outputs below gate them by state.
    always_ff @(posedge clk) begin
        if (state == IDLE && found) begin
            addr_r <= addr_a[winner];
            bc_r   <= bc_a[winner];
        end
    end

    assign gsel = NUM_REQ'(1) << grant;

    assign rq_ready  = ack   ? gsel : '0;
    assign rq_wready = wbeat ? gsel : '0;
    assign rq_rvalid = rbeat ? gsel : '0;
    assign rq_done   = done  ? gsel : '0;
    assign rq_rdata  = rbeat ? avm_readdata : '0;

    assign avm_address    = (state == WR || state == RD_CMD) ? addr_r : '0;
    assign avm_burstcount = (state == WR || state == RD_CMD) ? bc_r : '0;
    assign avm_writedata  = (state == WR) ? wd_a[grant] : '0;
    assign avm_byteenable = (state == WR) ? be_a[grant] : '0;

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Scoreboard bench for avalon_burst_arbiter: directed bursts, expected events queued at issue.
module tb_avalon_burst_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 64;
    localparam int BEW     = 8;
    localparam int BCW     = 11;

    localparam int K_RDY  = 0;
    localparam int K_WB   = 1;
    localparam int K_RB   = 2;
    localparam int K_DONE = 3;

    logic                   clk;
    logic                   arst;
    logic [NUM_REQ-1:0]     rq_valid;
    logic [NUM_REQ-1:0]     rq_write;
    logic [NUM_REQ*AW-1:0]  rq_addr;
    logic [NUM_REQ*BCW-1:0] rq_burstcount;
    logic [NUM_REQ*BEW-1:0] rq_byteenable;
    logic [NUM_REQ*DW-1:0]  rq_wdata;
    logic [NUM_REQ-1:0]     rq_ready;
    logic [NUM_REQ-1:0]     rq_wready;
    logic [NUM_REQ-1:0]     rq_rvalid;
    logic [DW-1:0]          rq_rdata;
    logic [NUM_REQ-1:0]     rq_done;
    logic [AW-1:0]          avm_address;
    logic [BCW-1:0]         avm_burstcount;
    logic                   avm_beginbursttransfer;
    logic                   avm_chipselect;
    logic                   avm_read;
    logic                   avm_write;
    logic [BEW-1:0]         avm_byteenable;
    logic [DW-1:0]          avm_writedata;
    logic [DW-1:0]          avm_readdata;
    logic                   avm_waitrequest;
    logic                   avm_readdatavalid;

    avalon_burst_arbiter #(
        .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .BEW(BEW), .BCW(BCW)
    ) dut (
        .clk(clk),
        .arst(arst),
        .rq_valid(rq_valid),
        .rq_write(rq_write),
        .rq_addr(rq_addr),
        .rq_burstcount(rq_burstcount),
        .rq_byteenable(rq_byteenable),
        .rq_wdata(rq_wdata),
        .rq_ready(rq_ready),
        .rq_wready(rq_wready),
        .rq_rvalid(rq_rvalid),
        .rq_rdata(rq_rdata),
        .rq_done(rq_done),
        .avm_address(avm_address),
        .avm_burstcount(avm_burstcount),
        .avm_beginbursttransfer(avm_beginbursttransfer),
        .avm_chipselect(avm_chipselect),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          req;
        logic [63:0] data;
    } ev_t;

    ev_t q[$];

    int tests    = 0;
    int errors   = 0;
    int done_cnt = 0;
    int rdy_cnt  [NUM_REQ];
    int rdy_base [NUM_REQ];
    int wb_cnt   [NUM_REQ];
    int wbase    [NUM_REQ];
    logic [NUM_REQ-1:0] hold;

    function automatic logic [63:0] wpat(int i, int k);
        return {32'hA500_0000 + 32'(i*256 + k), 32'h0F0F_0000 + 32'(k)};
    endfunction

    function automatic logic [63:0] rpat(int k);
        return {32'hC0DE_0000 + 32'(k), 32'h1234_5600 + 32'(k)};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic see(int kind, int req, logic [63:0] data);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d req=%0d data=%0h, required none", kind, req, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.req != req || e.data !== data) begin
                errors++;
                $display("FAIL event: got kind=%0d req=%0d data=%0h, required kind=%0d req=%0d data=%0h",
                         kind, req, data, e.kind, e.req, e.data);
            end
        end
    endtask

    task automatic push(int kind, int req, logic [63:0] data);
        ev_t e;
        e.kind = kind;
        e.req  = req;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic exp_burst(int i, bit wr, int bc, int k0);
        push(K_RDY, i, 64'd0);
        for (int k = 0; k < bc; k++)
            push(wr ? K_WB : K_RB, i, wr ? wpat(i, k0 + k) : rpat(k));
        push(K_DONE, i, 64'd0);
    endtask

    task automatic run_monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (rq_ready[i]) begin rdy_cnt[i]++; see(K_RDY, i, 64'd0); end
            for (int i = 0; i < NUM_REQ; i++)
                if (rq_wready[i]) begin wb_cnt[i]++; see(K_WB, i, avm_writedata); end
            for (int i = 0; i < NUM_REQ; i++)
                if (rq_rvalid[i]) see(K_RB, i, rq_rdata);
            for (int i = 0; i < NUM_REQ; i++)
                if (rq_done[i]) begin done_cnt++; see(K_DONE, i, 64'd0); end
        end
    endtask

    // Requester model: advance write data per consumed beat, drop valid after acceptance.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_wdata[i*DW +: DW] = wpat(i, wb_cnt[i] - wbase[i]);
            if (!hold[i] && rdy_cnt[i] != rdy_base[i])
                rq_valid[i] = 1'b0;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(int i, bit wr, logic [AW-1:0] addr, int bc, logic [BEW-1:0] be);
        rq_write[i]                  = wr;
        rq_addr[i*AW +: AW]          = addr;
        rq_burstcount[i*BCW +: BCW]  = BCW'(bc);
        rq_byteenable[i*BEW +: BEW]  = be;
        wbase[i]                     = wb_cnt[i];
        rdy_base[i]                  = rdy_cnt[i];
        rq_wdata[i*DW +: DW]         = wpat(i, 0);
        rq_valid[i]                  = 1'b1;
    endtask

    task automatic wait_done(int n, int budget, string nm);
        int target;
        target = done_cnt + n;
        for (int c = 0; c < budget && done_cnt < target; c++) begin
            tick();
            to_neg();
        end
        tests++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s timeout: done pulses %0d, required %0d", nm, done_cnt, target);
        end
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_rq_flags"}, 64'({rq_ready, rq_wready, rq_rvalid, rq_done}), 64'd0);
        chk({nm, "_rq_rdata"}, rq_rdata, 64'd0);
        chk({nm, "_avm_ctl"}, 64'({avm_chipselect, avm_read, avm_write, avm_beginbursttransfer}), 64'd0);
        chk({nm, "_avm_addr"}, 64'(avm_address), 64'd0);
        chk({nm, "_avm_bc"}, 64'(avm_burstcount), 64'd0);
        chk({nm, "_avm_wdata"}, avm_writedata, 64'd0);
        chk({nm, "_avm_be"}, 64'(avm_byteenable), 64'd0);
    endtask

    task automatic run_stimulus();
        arst              = 1'b0;
        rq_valid          = '0;
        rq_write          = '0;
        rq_addr           = '0;
        rq_burstcount     = '0;
        rq_byteenable     = '0;
        rq_wdata          = '0;
        hold              = '0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata      = rpat(9);
        for (int i = 0; i < NUM_REQ; i++) begin
            rdy_cnt[i] = 0; rdy_base[i] = 0; wb_cnt[i] = 0; wbase[i] = 0;
        end
        repeat (3) @(posedge clk);
        to_neg();
        chk_all_zero("reset");

        tick();
        arst              = 1'b1;
        avm_readdatavalid = 1'b0;
        tick();

        // Fairness: both requesters continuously valid.
        hold = '1;
        issue(0, 1'b1, 32'h400, 1, 8'hFF);
        issue(1, 1'b1, 32'h500, 1, 8'h0F);
        exp_burst(0, 1'b1, 1, 0);
        exp_burst(1, 1'b1, 1, 0);
        exp_burst(0, 1'b1, 1, 1);
        exp_burst(1, 1'b1, 1, 1);
        wait_done(4, 40, "fair");
        tick();
        rq_valid = '0;
        hold     = '0;
        tick();
        to_neg();
        chk("fair_idle_cs", 64'(avm_chipselect), 64'd0);

        // Single write burst of 4 beats.
        tick();
        issue(0, 1'b1, 32'h100, 4, 8'hF0);
        exp_burst(0, 1'b1, 4, 0);
        tick(); to_neg();
        chk("w1_begin", 64'(avm_beginbursttransfer), 64'd1);
        chk("w1_write", 64'(avm_write), 64'd1);
        chk("w1_cs", 64'(avm_chipselect), 64'd1);
        chk("w1_addr", 64'(avm_address), 64'h100);
        chk("w1_bc", 64'(avm_burstcount), 64'd4);
        chk("w1_be", 64'(avm_byteenable), 64'hF0);
        for (int c = 2; c <= 4; c++) begin
            tick(); to_neg();
            chk("w1_begin_off", 64'(avm_beginbursttransfer), 64'd0);
            chk("w1_write_hold", 64'(avm_write), 64'd1);
        end
        tick(); to_neg();
        chk("w1_idle_write", 64'(avm_write), 64'd0);
        chk("w1_idle_cs", 64'(avm_chipselect), 64'd0);

        // Read burst with two wait cycles and gapped readdatavalid.
        tick();
        issue(1, 1'b0, 32'h40, 3, 8'h00);
        avm_waitrequest = 1'b1;
        exp_burst(1, 1'b0, 3, 0);
        tick(); to_neg();
        chk("r_read", 64'(avm_read), 64'd1);
        chk("r_begin", 64'(avm_beginbursttransfer), 64'd1);
        chk("r_addr", 64'(avm_address), 64'h40);
        chk("r_bc", 64'(avm_burstcount), 64'd3);
        tick(); to_neg();
        chk("r_read_hold", 64'(avm_read), 64'd1);
        chk("r_begin_off", 64'(avm_beginbursttransfer), 64'd0);
        tick();
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata      = rpat(0);
        to_neg();
        chk("r_read_accept", 64'(avm_read), 64'd1);
        tick();
        avm_readdatavalid = 1'b0;
        to_neg();
        chk("r_read_drop", 64'(avm_read), 64'd0);
        chk("r_cs_drop", 64'(avm_chipselect), 64'd0);
        tick();
        avm_readdatavalid = 1'b1;
        avm_readdata      = rpat(1);
        to_neg();
        tick();
        avm_readdata = rpat(2);
        to_neg();
        tick();
        avm_readdata = rpat(7);
        to_neg();
        chk("r_idle_cs", 64'(avm_chipselect), 64'd0);
        tick();
        avm_readdatavalid = 1'b0;
        to_neg();

        // Write burst of 2 beats under toggling waitrequest.
        tick();
        issue(0, 1'b1, 32'h200, 2, 8'h3C);
        avm_waitrequest = 1'b1;
        exp_burst(0, 1'b1, 2, 0);
        tick(); to_neg();
        chk("b_begin", 64'(avm_beginbursttransfer), 64'd1);
        tick();
        avm_waitrequest = 1'b0;
        to_neg();
        tick();
        avm_waitrequest = 1'b1;
        to_neg();
        chk("b_write_hold", 64'(avm_write), 64'd1);
        chk("b_wdata_track", avm_writedata, wpat(0, 1));
        tick();
        avm_waitrequest = 1'b0;
        to_neg();
        tick(); to_neg();
        chk("b_idle_write", 64'(avm_write), 64'd0);

        // Zero-length burst: accept and done together, no bus activity.
        tick();
        issue(0, 1'b1, 32'h300, 0, 8'hFF);
        exp_burst(0, 1'b1, 0, 0);
        tick(); to_neg();
        chk("z_bus", 64'({avm_chipselect, avm_write, avm_read, avm_beginbursttransfer}), 64'd0);
        tick(); to_neg();
        chk("z_cs_after", 64'(avm_chipselect), 64'd0);

        // Reset during beat 2 of a 4-beat write.
        tick();
        issue(0, 1'b1, 32'h600, 4, 8'hFF);
        push(K_RDY, 0, 64'd0);
        push(K_WB, 0, wpat(0, 0));
        tick(); to_neg();
        tick();
        #1;
        arst = 1'b0;
        #1;
        chk_all_zero("midrst");
        to_neg();
        tick();
        tick();
        issue(0, 1'b1, 32'h700, 1, 8'hFF);
        issue(1, 1'b1, 32'h800, 1, 8'hFF);
        exp_burst(0, 1'b1, 1, 0);
        exp_burst(1, 1'b1, 1, 0);
        arst = 1'b1;
        wait_done(2, 20, "midrst_after");
        tick(); to_neg();
        tick(); to_neg();
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        fork
            run_monitor();
            run_stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avalon_burst_arbiter.md
Name: avalon_burst_arbiter

Overview:
- Shares one Avalon-MM burst master port between NUM_REQ requester engines of the curl calc unit, e.g. a nonce-state loader and a result writer.
- Grants one requester at a time using round-robin arbitration.
- Sequences a complete read or write burst on the bus and holds the grant until the burst is finished.
- Read data and write-beat handshakes are routed back to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- AW, 32, address width.
- DW, 1024, data width.
- BEW, DW/8, byteenable width.
- BCW, 11, burstcount width.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- arst  in  1  asynchronous, active-low reset.
- rq_valid  in  NUM_REQ  command request per requester; held until rq_ready.
- rq_write  in  NUM_REQ  1 = write burst, 0 = read burst.
- rq_addr  in  NUM_REQ*AW  burst start address.
- rq_burstcount  in  NUM_REQ*BCW  beats in the burst.
- rq_byteenable  in  NUM_REQ*BEW  byteenable for every write beat.
- rq_wdata  in  NUM_REQ*DW  current write beat; advanced by requester on rq_wready.
- rq_ready  out  NUM_REQ  1-cycle pulse: command accepted.
- rq_wready  out  NUM_REQ  write beat consumed this cycle.
- rq_rvalid  out  NUM_REQ  read beat valid on rq_rdata.
- rq_rdata  out  DW  shared read data.
- rq_done  out  NUM_REQ  1-cycle pulse: burst complete.
- avm_address  out  AW; avm_burstcount  out  BCW; avm_beginbursttransfer  out  1.
- avm_chipselect  out  1; avm_read  out  1; avm_write  out  1.
- avm_byteenable  out  BEW; avm_writedata  out  DW.
- avm_readdata  in  DW; avm_waitrequest  in  1; avm_readdatavalid  in  1.

Behaviour:
- Reset (arst=0, asynchronous):
  - state=IDLE, last_grant=NUM_REQ-1, beat counter=0.
  - All rq_* and avm_* outputs are 0.
  - An in-flight burst is abandoned with no rq_done.
- Round-robin arbitration in IDLE:
  - The winner is the first asserted rq_valid searching from last_grant+1 upward, with wrap-around.
  - last_grant is updated to the winner.
  - Grant is registered; rq_ready[winner] pulses in the cycle after rq_valid is sampled, which is also the first cycle the bus command is driven.
- burstcount=0: the command is accepted (rq_ready) and rq_done pulses in the same cycle. No bus activity occurs; the next state is IDLE.
- Write burst, state WR:
  - avm_write=avm_chipselect=1.
  - avm_address and avm_burstcount are registered from the granted requester.
  - avm_beginbursttransfer=1 for the first bus cycle only.
  - avm_writedata and avm_byteenable are a combinational mux of the granted requester.
  - A beat completes when avm_write & !avm_waitrequest. rq_wready[g] equals that term, combinationally.
  - The beat counter increments per completed beat. On the last beat: rq_done[g] pulses, avm_write and avm_chipselect drop next cycle, state goes to IDLE.
- Read burst:
  - RD_CMD: avm_read=avm_chipselect=1 and avm_beginbursttransfer=1 on the first cycle. The command holds while avm_waitrequest=1. Once accepted, read and chipselect drop next cycle and state goes to RD_DATA.
  - RD_DATA: each avm_readdatavalid gives rq_rvalid[g]=1 with rq_rdata=avm_readdata, combinationally. The beat counter counts these beats.
  - The last beat pulses rq_done[g] in the same cycle; state goes to IDLE.
  - readdatavalid may arrive in the RD_CMD accept cycle and is counted.
  - readdatavalid outside RD_CMD/RD_DATA is ignored.
- One burst is outstanding at a time. A new grant is evaluated only in IDLE, so there is a minimum 1 idle bus cycle between bursts.
- avm_address and avm_burstcount are stable for the whole command phase. The beat counter is BCW bits wide and never wraps, since the burst ends at burstcount.
- Non-granted requesters see rq_ready, rq_wready, rq_rvalid and rq_done all 0. A requester deasserting rq_valid before rq_ready is a protocol violation.

Test Plan:
- Single write: rq0 addr=0x100, burstcount=4, waitrequest=0 → beginbursttransfer in 1 cycle, 4 consecutive rq_wready[0] cycles, rq_done[0] on beat 4, bus idle next cycle.
- Read with wait: rq1 read addr=0x40, burstcount=3, waitrequest=1 for 2 cycles, readdatavalid gapped (V,-,V,V) → avm_read held for 3 cycles, 3 rq_rvalid[1] beats with matching data, rq_done[1] on the 3rd beat.
- Fairness: rq0 and rq1 both valid continuously after reset → grants alternate 0,1,0,1 over 4 bursts.
- Write backpressure: burstcount=2, waitrequest toggling 1,0,1,0 → exactly 2 rq_wready pulses; writedata tracks rq_wdata on each accepted beat.
- burstcount=0 on rq0 → rq_ready[0] and rq_done[0] pulse together; avm_chipselect stays 0.
- Reset mid-burst: arst=0 during beat 2 of a 4-beat write → all outputs 0 immediately, no rq_done; after release, rq0 is granted first.
